rstseq: RTL

//  Reset sequencer directly downstream of the device table. It consumes the

---
 rtl/rstseq.sv | 134 +++++++++++++
 1 files changed

// File: rtl/rstseq.sv
// Reset sequencer: power-on hold, reboot, halt and core restart,
// driven by devtbl reset flags and a debounced push-button.
module rstseq #(
    parameter int PORCYCLES  = 64,
    parameter int HOLDCYCLES = 16,
    parameter int DBNCBITSZ  = 10
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    input  logic rst0_i,
    input  logic rst1_i,
    input  logic rst2_i,
    output logic sysrst_o,
    output logic cpurst_o,
    output logic halted_o
);

    localparam int MAXCYC = (PORCYCLES > HOLDCYCLES) ? PORCYCLES : HOLDCYCLES;
    localparam int CW     = (MAXCYC > 1) ? $clog2(MAXCYC) : 1;

    localparam logic [CW-1:0]        POR_LD  = CW'(PORCYCLES - 1);
    localparam logic [CW-1:0]        HOLD_LD = CW'(HOLDCYCLES - 1);
    localparam logic [DBNCBITSZ-1:0] DB_MAX  = '1;
    localparam logic [DBNCBITSZ-1:0] DB_PRE  = DB_MAX - DBNCBITSZ'(1);

    typedef enum logic [2:0] {
        S_POR  = 3'd0,
        S_RUN  = 3'd1,
        S_HOLD = 3'd2,
        S_CORE = 3'd3,
        S_HALT = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [1:0]             sync_q;
    logic [DBNCBITSZ-1:0]   dbnc_q;
    logic                   press_q;
    logic                   sys_d, cpu_d, halt_d;

    // Press fires once when the counter saturates; release re-arms it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= 2'b00;
            dbnc_q  <= '0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            press_q <= 1'b0;
            if (!sync_q[1]) begin
                dbnc_q <= '0;
            end else if (dbnc_q != DB_MAX) begin
                dbnc_q  <= dbnc_q + DBNCBITSZ'(1);
                press_q <= (dbnc_q == DB_PRE);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_POR, S_HOLD: begin
                if (cnt_q == '0) state_d = S_RUN;
                else             cnt_d   = cnt_q - CW'(1);
            end
            S_RUN: begin
                if (press_q || rst1_i) begin
                    state_d = S_HOLD;
                    cnt_d   = HOLD_LD;
                end else if (rst0_i) begin
                    state_d = S_HALT;
                end else if (rst2_i) begin
                    state_d = S_CORE;
                    cnt_d   = HOLD_LD;
                end
            end
            S_CORE: begin
                if (press_q) begin
                    state_d = S_HOLD;
                    cnt_d   = HOLD_LD;
                end else if (cnt_q == '0) begin
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_HALT: begin
                if (press_q) begin
                    state_d = S_HOLD;
                    cnt_d   = HOLD_LD;
                end
            end
            default: begin
                state_d = S_POR;
                cnt_d   = POR_LD;
            end
        endcase
    end

    // Outputs decode the next state so they stay aligned with the state flop.
    always_comb begin
        sys_d  = 1'b1;
        cpu_d  = 1'b1;
        halt_d = 1'b0;
        case (state_d)
            S_RUN: begin
                sys_d = 1'b0;
                cpu_d = 1'b0;
            end
            S_CORE:  sys_d  = 1'b0;
            S_HALT:  halt_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_POR;
            cnt_q    <= POR_LD;
            sysrst_o <= 1'b1;
            cpurst_o <= 1'b1;
            halted_o <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sysrst_o <= sys_d;
            cpurst_o <= cpu_d;
            halted_o <= halt_d;
        end
    end

endmodule
